// File: rtl/btn_pkg.sv
// btn_pkg: shared state encoding and counter-width helper for the button event decoder
package btn_pkg;
  typedef enum logic [1:0] {IDLE, PRESSED, LONG_HOLD} btn_state_t;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/debounce_filter.sv
// debounce_filter: 2-FF synchronizer plus debounce counter for the raw button pin
// Ports: clk_16mhz/rst_n (async active-low), btn_usr raw pin; btn_level debounced (1 = pressed),
// press_pulse/release_pulse registered edge strobes, press_nxt/release_nxt the same edges one cycle early.
module debounce_filter
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 320000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk_16mhz,
  input  logic rst_n,
  input  logic btn_usr,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic press_nxt,
  output logic release_nxt
);
  localparam int DW = cnt_w(DEBOUNCE_CYCLES);
  logic sync1_q, sync2_q, sync_p, done;
  logic level_q, level_d, press_q, release_q;
  logic [DW-1:0] cnt_q, cnt_d;
  assign sync_p = sync2_q ^ ACTIVE_LOW;
  assign done   = (sync_p != level_q) && (cnt_q == DW'(DEBOUNCE_CYCLES - 1));
  always_comb begin
    cnt_d       = (sync_p == level_q || done) ? '0 : cnt_q + 1'b1;
    level_d     = done ? sync_p : level_q;
    press_nxt   = done & sync_p;
    release_nxt = done & ~sync_p;
  end
  // Sync flops reset to the idle pin level so a button held through reset is seen as a new press.
  always_ff @(posedge clk_16mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= ACTIVE_LOW;
      sync2_q   <= ACTIVE_LOW;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= btn_usr;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_nxt;
      release_q <= release_nxt;
    end
  end
  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
endmodule

// File: rtl/button_event_decoder.sv
// button_event_decoder: turns the raw pushbutton into press/release/short/long/double-click events
// Ports: clk_16mhz, rst_n (async active-low), btn_usr raw pin; btn_level, press_pulse, release_pulse,
// short_pulse, long_pulse, held, dbl_pulse outputs. Define BTN_DBLCLICK_EN to build double-click
// detection; otherwise dbl_pulse is tied low.
module button_event_decoder
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 320000,
  parameter int LONG_CYCLES       = 16000000,
  parameter int DBL_WINDOW_CYCLES = 6400000,
  parameter bit ACTIVE_LOW        = 1'b1
) (
  input  logic clk_16mhz,
  input  logic rst_n,
  input  logic btn_usr,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic held,
  output logic dbl_pulse
);
  localparam int HW = cnt_w(LONG_CYCLES);
  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES || DBL_WINDOW_CYCLES < 1) begin : g_bad_params
    $error("button_event_decoder: invalid timing parameters");
  end
  logic press_nxt, release_nxt;
  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .ACTIVE_LOW     (ACTIVE_LOW)
  ) u_filter (
    .clk_16mhz    (clk_16mhz),
    .rst_n        (rst_n),
    .btn_usr      (btn_usr),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .press_nxt    (press_nxt),
    .release_nxt  (release_nxt)
  );
  btn_state_t state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic short_q, short_d, long_q, long_d, held_q, held_d;
  // The filter's early edge strobes let short/long line up with its registered release pulse.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    unique case (state_q)
      IDLE: if (press_nxt) begin
        state_d = PRESSED;
        hold_d  = '0;
      end
      // Release is checked first so a release on the last hold cycle is still a short click.
      PRESSED: if (release_nxt) begin
        state_d = IDLE;
        short_d = 1'b1;
      end else if (hold_q == HW'(LONG_CYCLES - 1)) begin
        state_d = LONG_HOLD;
        long_d  = 1'b1;
      end else hold_d = hold_q + 1'b1;
      LONG_HOLD: if (release_nxt) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    held_d = (state_d == LONG_HOLD);
  end
  always_ff @(posedge clk_16mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      short_q <= short_d;
      long_q  <= long_d;
      held_q  <= held_d;
    end
  end
  assign short_pulse = short_q;
  assign long_pulse  = long_q;
  assign held        = held_q;
`ifdef BTN_DBLCLICK_EN
  localparam int WW = cnt_w(DBL_WINDOW_CYCLES);
  logic [WW-1:0] win_q, win_d;
  logic win_open_q, win_open_d, armed_q, armed_d, dbl_q, dbl_d, win_last, reopen;
  assign win_last = (win_q == WW'(DBL_WINDOW_CYCLES - 1));
  // A click that completes a double click does not start a new window.
  assign reopen   = short_d & ~dbl_d;
  always_comb begin
    dbl_d      = short_d & armed_q;
    armed_d    = (short_d | long_d) ? 1'b0 : (press_nxt & win_open_q) ? 1'b1 : armed_q;
    win_open_d = reopen ? 1'b1 : (press_nxt | win_last) ? 1'b0 : win_open_q;
    win_d      = reopen ? '0 : (win_open_q & ~press_nxt & ~win_last) ? win_q + 1'b1 : win_q;
  end
  always_ff @(posedge clk_16mhz or negedge rst_n) begin
    if (!rst_n) begin
      win_q      <= '0;
      win_open_q <= 1'b0;
      armed_q    <= 1'b0;
      dbl_q      <= 1'b0;
    end else begin
      win_q      <= win_d;
      win_open_q <= win_open_d;
      armed_q    <= armed_d;
      dbl_q      <= dbl_d;
    end
  end
  assign dbl_pulse = dbl_q;
`else
  assign dbl_pulse = 1'b0;
`endif
endmodule

// File: tb/tb_button_event_decoder.sv
// tb_button_event_decoder: scoreboard bench for button_event_decoder with small timing parameters
module tb_button_event_decoder;
`ifdef BTN_DBLCLICK_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif
  typedef struct {int cyc; logic [5:0] f;} ev_t;
  logic clk = 1'b0, rst_n = 1'b0, btn_usr = 1'b1;
  logic btn_level, press_pulse, release_pulse, short_pulse, long_pulse, held, dbl_pulse;
  int cyc = 0, checks = 0, failures = 0;
  ev_t exp_q[$];
  button_event_decoder #(
    .DEBOUNCE_CYCLES  (4),
    .LONG_CYCLES      (20),
    .DBL_WINDOW_CYCLES(30),
    .ACTIVE_LOW       (1'b1)
  ) dut (
    .clk_16mhz    (clk),
    .rst_n        (rst_n),
    .btn_usr      (btn_usr),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .held         (held),
    .dbl_pulse    (dbl_pulse)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Event field order: {press, release, short, long, dbl, held}
  task automatic push(input int c, input logic [5:0] f);
    ev_t e;
    e.cyc = c;
    e.f   = f;
    exp_q.push_back(e);
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at cyc=%0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask
  always @(negedge clk) begin
    logic [5:0] act;
    ev_t e;
    act = {press_pulse, release_pulse, short_pulse, long_pulse, dbl_pulse, held};
    if (rst_n && (press_pulse | release_pulse | short_pulse | long_pulse | dbl_pulse)) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event at cyc=%0d: got prsl_dh=%b expected no event", cyc, act);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.f != act) begin
          failures++;
          $display("FAIL event: got cyc=%0d prsl_dh=%b expected cyc=%0d prsl_dh=%b", cyc, act, e.cyc, e.f);
        end
      end
    end
  end
  initial begin
    int c;
    idle(3);
    check("reset_outputs", int'({btn_level, press_pulse, release_pulse, short_pulse, long_pulse, held, dbl_pulse}), 0);
    rst_n = 1'b1;
    idle(5);
    // Reset asserted mid-press, then released with the button still held.
    c = cyc;
    push(c + 6, 6'b100000);
    btn_usr = 1'b0;
    idle(10);
    #2 rst_n = 1'b0;
    #1 check("reset_mid_press", int'({btn_level, press_pulse, release_pulse, short_pulse, long_pulse, held, dbl_pulse}), 0);
    idle(3);
    rst_n = 1'b1;
    c = cyc;
    push(c + 6, 6'b100000);
    push(c + 16, 6'b011000);
    idle(5);
    check("level_after_reset_pre", int'(btn_level), 0);
    idle(2);
    check("level_after_reset", int'(btn_level), 1);
    idle(3);
    btn_usr = 1'b1;
    idle(50);
    // Glitch of 3 cycles is rejected.
    btn_usr = 1'b0;
    idle(3);
    btn_usr = 1'b1;
    idle(10);
    check("glitch_level", int'(btn_level), 0);
    idle(20);
    // Short click.
    c = cyc;
    push(c + 6, 6'b100000);
    push(c + 16, 6'b011000);
    btn_usr = 1'b0;
    idle(10);
    btn_usr = 1'b1;
    idle(50);
    // Long hold.
    c = cyc;
    push(c + 6, 6'b100000);
    push(c + 26, 6'b000101);
    push(c + 46, 6'b010000);
    btn_usr = 1'b0;
    idle(30);
    check("held_mid", int'(held), 1);
    idle(10);
    btn_usr = 1'b1;
    idle(5);
    check("held_before_release", int'(held), 1);
    idle(5);
    check("held_after_release", int'(held), 0);
    idle(50);
    // Release lands on the last hold cycle: short wins.
    c = cyc;
    push(c + 6, 6'b100000);
    push(c + 26, 6'b011000);
    btn_usr = 1'b0;
    idle(20);
    btn_usr = 1'b1;
    idle(50);
    // One cycle longer: long hold, then plain release.
    c = cyc;
    push(c + 6, 6'b100000);
    push(c + 26, 6'b000101);
    push(c + 27, 6'b010000);
    btn_usr = 1'b0;
    idle(21);
    btn_usr = 1'b1;
    idle(50);
    // Double click with a 12-cycle gap, then a third quick click that must not double.
    c = cyc;
    push(c + 6, 6'b100000);
    push(c + 16, 6'b011000);
    push(c + 28, 6'b100000);
    push(c + 38, {4'b0110, DBL, 1'b0});
    push(c + 50, 6'b100000);
    push(c + 60, 6'b011000);
    btn_usr = 1'b0;
    idle(10);
    btn_usr = 1'b1;
    idle(12);
    btn_usr = 1'b0;
    idle(10);
    btn_usr = 1'b1;
    idle(12);
    btn_usr = 1'b0;
    idle(10);
    btn_usr = 1'b1;
    idle(60);
    // Gap of 40 cycles exceeds the window.
    c = cyc;
    push(c + 6, 6'b100000);
    push(c + 16, 6'b011000);
    push(c + 56, 6'b100000);
    push(c + 66, 6'b011000);
    btn_usr = 1'b0;
    idle(10);
    btn_usr = 1'b1;
    idle(40);
    btn_usr = 1'b0;
    idle(10);
    btn_usr = 1'b1;
    idle(30);
    check("pending_events", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Reads the active-low user pushbutton (btn_usr) and turns it into clean, single-cycle events for the rest of the design: press, release, short click and long hold.
- Sits between the board button pin and any logic that consumes user input, such as mode selection or LED pattern control.
- Contains a 2-FF input synchronizer, a debounce filter and a press-classification FSM.

Parameters:
- DEBOUNCE_CYCLES, 320000, cycles the synchronized input must hold a new level before it is accepted (20 ms at 16 MHz); must be >= 2.
- LONG_CYCLES, 16000000, cycles of debounced press before a long hold is declared (1 s); must be greater than DEBOUNCE_CYCLES.
- DBL_WINDOW_CYCLES, 6400000, maximum cycles from a short-click release to the next press for that press to count as a double click (400 ms).
- ACTIVE_LOW, 1, 1 means a raw level of 0 on btn_usr is "pressed".

Ports:
- clk_16mhz  in  1  system clock, 16 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- btn_usr  in  1  raw button pin, asynchronous to the clock.
- btn_level  out  1  debounced level, 1 = pressed.
- press_pulse  out  1  one-cycle pulse on a debounced press.
- release_pulse  out  1  one-cycle pulse on a debounced release.
- short_pulse  out  1  one-cycle pulse on a release before LONG_CYCLES has elapsed.
- long_pulse  out  1  one-cycle pulse when the press reaches LONG_CYCLES.
- held  out  1  high while in LONG_HOLD.
- dbl_pulse  out  1  one-cycle double-click pulse; see Optional Feature.

Behaviour:
- Reset: one clock, clk_16mhz; rst_n is asynchronous active-low. While rst_n is low:
  - All outputs are 0.
  - Synchronizer flops load the idle raw level (1 if ACTIVE_LOW).
  - All counters are 0; FSM is in IDLE.
  - A button held through the rising edge of rst_n registers as a press once debounce completes.
- Synchronizer: 2 flops. sync_p is the second flop, polarity-corrected so that 1 = pressed.
- Debounce counter:
  - Width is $clog2(DEBOUNCE_CYCLES).
  - If sync_p == btn_level, the counter clears.
  - Otherwise it increments; when it equals DEBOUNCE_CYCLES-1, btn_level <= sync_p and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES restarts the count.
  - Latency from a clean pin edge to btn_level: 2 + DEBOUNCE_CYCLES cycles.
- Edge pulses: press_pulse and release_pulse assert in the same cycle btn_level changes (registered, one cycle wide).
- FSM states: IDLE, PRESSED, LONG_HOLD.
  - IDLE -> PRESSED on a press edge. The hold counter clears.
  - PRESSED: the hold counter increments each cycle.
  - PRESSED -> LONG_HOLD when the hold counter reaches LONG_CYCLES-1. long_pulse asserts for 1 cycle and held goes to 1.
  - PRESSED -> IDLE on a release edge. short_pulse asserts in the same cycle as release_pulse.
  - LONG_HOLD -> IDLE on a release edge. release_pulse only; held goes to 0 in that cycle; no short_pulse.
  - The hold counter is $clog2(LONG_CYCLES) wide and saturates; it never wraps.
- Simultaneous events: a release in the same cycle the hold counter reaches LONG_CYCLES-1 wins. The result is short_pulse, with no long_pulse.
- At most one of press_pulse/release_pulse is asserted per cycle.

Optional Feature:
- Macro: BTN_DBLCLICK_EN.
- When defined:
  - A window counter starts at 0 on each short_pulse and counts to DBL_WINDOW_CYCLES-1, then goes idle.
  - A press edge while the window is open arms the double-click condition and closes the window.
  - If that press then ends in a short release, dbl_pulse asserts in the same cycle as that short_pulse; short_pulse still fires.
  - A long hold disarms the condition.
  - After a dbl_pulse, the window does not reopen.
- When undefined: dbl_pulse is tied to 0, no window logic is synthesized, and the port list is unchanged.

Decomposition:
- Package btn_pkg holds:
  - State enum btn_state_t: IDLE, PRESSED, LONG_HOLD.
  - Localparam width helpers.
- Sub-module debounce_filter contains the synchronizer and debounce counter and outputs btn_level plus edge strobes.
- The FSM and double-click logic stay in the top.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, LONG_CYCLES=20, DBL_WINDOW_CYCLES=30, ACTIVE_LOW=1.
1. Reset values: assert rst_n=0 mid-press (btn_usr=0) -> all outputs 0 immediately. Release reset with the button still held -> press_pulse 6 cycles later.
2. Glitch rejection: btn_usr low for 3 cycles, then high -> no press_pulse; btn_level stays 0.
3. Short click: btn_usr low for 10 cycles -> press_pulse at cycle 6; release_pulse and short_pulse in the same cycle, 6 cycles after the pin rises; no long_pulse.
4. Long hold: btn_usr low for 40 cycles -> long_pulse exactly 20 cycles after press_pulse; held=1 until release; release_pulse with no short_pulse.
5. Boundary: release edge lands in the cycle the hold count reaches 19 -> short_pulse=1, long_pulse=0.
6. Double click (macro on): two 10-cycle presses 12 cycles apart -> second release gives short_pulse and dbl_pulse together. With a 40-cycle gap -> no dbl_pulse. Macro off -> dbl_pulse is always 0.
